// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths and the instruction-queue entry type for the fetch stage.
package fetch_pkg;
  localparam int IMEM_AW = 6;
  localparam int INST_W = 32;
  localparam int PC_MAX_W = 64;
  typedef struct packed {
    logic [PC_MAX_W-1:0] pc;
    logic [INST_W-1:0]   inst;
  } entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry instruction queue with push/pop/flush and a zeroed head when empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_flush,
  input  entry_t                 i_data,
  output entry_t                 o_head,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int AW = $clog2(DEPTH);
  entry_t r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0] r_count;
  logic w_pop, w_push;
  assign w_pop = i_pop && !i_flush && r_count != '0;
  // A full queue only accepts a push when the head leaves in the same cycle.
  assign w_push = i_push && !i_flush && (r_count != (AW+1)'(DEPTH) || w_pop);
  assign o_head = r_count != '0 ? r_mem[r_rd] : '0;
  assign o_count = r_count;
  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_wr <= '0;
      r_rd <= '0;
      r_count <= '0;
    end else begin
      r_wr <= w_push ? r_wr + AW'(1) : r_wr;
      r_rd <= w_pop ? r_rd + AW'(1) : r_rd;
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr] <= i_data;
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: sequential instruction fetch from a combinational imem into a small queue,
// with branch redirect flushing the queue.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int N = 64,
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [INST_W-1:0]  imem_q,
  input  logic               br_taken,
  input  logic [N-1:0]       br_target,
  output logic               inst_valid,
  output logic [INST_W-1:0]  inst,
  output logic [N-1:0]       inst_pc,
  input  logic               inst_ready
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [N-1:0] r_pc;
  logic [CW-1:0] w_count;
  entry_t w_head, w_wdata;
  logic w_pop, w_push;
  assign imem_addr = r_pc[7:2];
  assign inst_valid = w_count != '0;
  assign w_pop = inst_valid && inst_ready;
  assign w_push = !br_taken && (w_count != CW'(DEPTH) || w_pop);
  assign w_wdata = '{pc: PC_MAX_W'(r_pc), inst: imem_q};
  assign inst = w_head.inst;
  assign inst_pc = w_head.pc[N-1:0];
  always_ff @(posedge clk) begin
    if (reset) r_pc <= '0;
    else if (br_taken) r_pc <= br_target & ~N'(3);
    else if (w_push) r_pc <= r_pc + N'(4);
  end
  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (br_taken),
    .i_data  (w_wdata),
    .o_head  (w_head),
    .o_count (w_count)
  );
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed and randomized checks of fetch_ctrl against a queue-based reference model.
module tb_fetch_ctrl;
  localparam int N = 64;
  localparam int DEPTH = 2;
  typedef struct {
    logic [N-1:0] pc;
    logic [31:0]  inst;
  } ent_t;
  logic clk = 0;
  logic reset = 1;
  logic [5:0] imem_addr;
  logic [31:0] imem_q;
  logic br_taken = 0;
  logic [N-1:0] br_target = '0;
  logic inst_valid;
  logic [31:0] inst;
  logic [N-1:0] inst_pc;
  logic inst_ready = 0;
  logic [31:0] mem [64];
  ent_t q[$];
  logic [N-1:0] m_pc;
  int checks = 0;
  int failures = 0;

  fetch_ctrl #(.N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_q(imem_q),
    .br_taken(br_taken), .br_target(br_target), .inst_valid(inst_valid),
    .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready)
  );

  assign imem_q = mem[imem_addr];
  always #5 clk = ~clk;

  task automatic cyc(input logic rdy, input logic tk, input logic [N-1:0] tgt, input logic rst);
    logic pop;
    reset = rst; br_taken = tk; br_target = tgt; inst_ready = rdy;
    if (rst) begin
      q.delete(); m_pc = '0;
    end else if (tk) begin
      q.delete(); m_pc = {tgt[N-1:2], 2'b00};
    end else begin
      pop = q.size() > 0 && rdy;
      if (pop) void'(q.pop_front());
      if (q.size() < DEPTH) begin
        q.push_back('{pc: m_pc, inst: mem[m_pc[7:2]]});
        m_pc = m_pc + 4;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    cyc(0, 1, 64'h80, 1);
    checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got %0d want 0", inst_valid); end
    checks++; if (inst !== 32'h0) begin failures++; $display("FAIL reset_inst got %h want 0", inst); end
    checks++; if (inst_pc !== '0) begin failures++; $display("FAIL reset_pc got %h want 0", inst_pc); end
    checks++; if (imem_addr !== 6'd0) begin failures++; $display("FAIL reset_addr got %0d want 0", imem_addr); end
  endtask

  task automatic test_stream;
    cyc(1, 0, '0, 1);
    for (int i = 0; i < 6; i++) begin
      cyc(1, 0, '0, 0);
      checks++; if (inst_valid !== 1'b1 || inst_pc !== N'(4*i)) begin failures++; $display("FAIL stream_pc[%0d] got %h want %h", i, inst_pc, N'(4*i)); end
      checks++; if (inst !== mem[i]) begin failures++; $display("FAIL stream_inst[%0d] got %h want %h", i, inst, mem[i]); end
    end
  endtask

  task automatic test_stall;
    cyc(0, 0, '0, 1);
    for (int i = 0; i < 5; i++) cyc(0, 0, '0, 0);
    checks++; if (inst_pc !== '0 || inst_valid !== 1'b1) begin failures++; $display("FAIL stall_pc got %h want 0", inst_pc); end
    checks++; if (imem_addr !== 6'd2) begin failures++; $display("FAIL stall_addr got %0d want 2", imem_addr); end
    for (int i = 1; i < 4; i++) begin
      cyc(1, 0, '0, 0);
      checks++; if (inst_pc !== N'(4*i) || inst !== mem[i]) begin failures++; $display("FAIL release_pc[%0d] got %h want %h", i, inst_pc, N'(4*i)); end
    end
  endtask

  task automatic test_redirect;
    cyc(0, 0, '0, 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, '0, 0);
    cyc(1, 1, 64'h43, 0);
    checks++; if (inst_valid !== 1'b0 || inst !== 32'h0) begin failures++; $display("FAIL redir_flush got valid=%0d inst=%h want 0/0", inst_valid, inst); end
    checks++; if (imem_addr !== 6'd16) begin failures++; $display("FAIL redir_addr got %0d want 16", imem_addr); end
    cyc(1, 0, '0, 0);
    checks++; if (inst_valid !== 1'b1 || inst_pc !== N'(64'h40)) begin failures++; $display("FAIL redir_pc got %h want 40", inst_pc); end
    checks++; if (inst !== mem[16]) begin failures++; $display("FAIL redir_inst got %h want %h", inst, mem[16]); end
  endtask

  task automatic test_wrap;
    logic [5:0] ea [5];
    logic [N-1:0] ep [4];
    ea = '{6'd62, 6'd63, 6'd0, 6'd1, 6'd2};
    ep = '{N'(64'hF8), N'(64'hFC), N'(64'h100), N'(64'h104)};
    cyc(1, 1, 64'hF8, 0);
    checks++; if (imem_addr !== ea[0]) begin failures++; $display("FAIL wrap_addr[0] got %0d want %0d", imem_addr, ea[0]); end
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, '0, 0);
      checks++; if (imem_addr !== ea[i+1]) begin failures++; $display("FAIL wrap_addr[%0d] got %0d want %0d", i+1, imem_addr, ea[i+1]); end
      checks++; if (inst_pc !== ep[i]) begin failures++; $display("FAIL wrap_pc[%0d] got %h want %h", i, inst_pc, ep[i]); end
    end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 3; i++) cyc(0, 0, '0, 0);
    cyc(1, 1, 64'h80, 1);
    checks++; if (inst_valid !== 1'b0 || imem_addr !== 6'd0) begin failures++; $display("FAIL rstmid got valid=%0d addr=%0d want 0/0", inst_valid, imem_addr); end
    cyc(1, 0, '0, 0);
    checks++; if (inst_valid !== 1'b1 || inst_pc !== '0 || inst !== mem[0]) begin failures++; $display("FAIL rstmid_first got pc=%h inst=%h want 0/%h", inst_pc, inst, mem[0]); end
  endtask

  task automatic test_random;
    logic [N-1:0] epc;
    logic [31:0] ein;
    cyc(1, 0, '0, 1);
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0), {$urandom, $urandom}, ($urandom_range(0, 49) == 0));
      epc = q.size() > 0 ? q[0].pc : '0;
      ein = q.size() > 0 ? q[0].inst : '0;
      checks++; if (inst_valid !== (q.size() > 0)) begin failures++; $display("FAIL rand_valid[%0d] got %0d want %0d", i, inst_valid, q.size() > 0); end
      checks++; if (inst_pc !== epc) begin failures++; $display("FAIL rand_pc[%0d] got %h want %h", i, inst_pc, epc); end
      checks++; if (inst !== ein) begin failures++; $display("FAIL rand_inst[%0d] got %h want %h", i, inst, ein); end
      checks++; if (imem_addr !== m_pc[7:2]) begin failures++; $display("FAIL rand_addr[%0d] got %0d want %0d", i, imem_addr, m_pc[7:2]); end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    m_pc = '0;
    test_reset;
    test_stream;
    test_stall;
    test_redirect;
    test_wrap;
    test_reset_mid;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter N, default 64, PC width in bits.
REQ-002 Parameter DEPTH, default 2, instruction-queue entries (power of two, >=2).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 imem_addr  output  6  word address driven to the combinational imem; equals pc[7:2].
REQ-006 imem_q  input  32  instruction returned by imem for imem_addr in the same cycle.
REQ-007 br_taken  input  1  redirect request from execute stage.
REQ-008 br_target  input  N  redirect PC; bits [1:0] ignored (treated as 0).
REQ-009 inst_valid  output  1  head of queue holds an instruction.
REQ-010 inst  output  32  head instruction; 0 when inst_valid=0.
REQ-011 inst_pc  output  N  PC of head instruction; 0 when inst_valid=0.
REQ-012 inst_ready  input  1  decode accepts head; pop when inst_valid && inst_ready.

Function
REQ-013 Internal pc register (N bits) always word-aligned; imem_addr = pc[7:2] combinationally.
REQ-014 Push: when not flushing and (count<DEPTH or pop this cycle), enqueue {pc, imem_q} and pc <= pc+4.
REQ-015 Full and no pop: no enqueue, pc holds, imem_addr stable.
REQ-016 Pop and push in the same cycle: count unchanged, both take effect.
REQ-017 Redirect (br_taken=1): queue flushed (count<=0), pc <= {br_target[N-1:2],2'b00}, no enqueue, pop ignored; inst_valid=0 next cycle.
REQ-018 First instruction at target appears at inst_valid one cycle after redirect cycle (latency 1).
REQ-019 Latency from reset release to first inst_valid = 1 cycle; then back-to-back one instruction per cycle while inst_ready=1.
REQ-020 pc wraps modulo 2^N; imem_addr wraps 63 -> 0 after pc[7:2]=63 with no special handling.
REQ-021 inst/inst_pc are registered queue outputs, not combinational from imem_q.
REQ-022 Queue order strictly FIFO; read/write pointers wrap modulo DEPTH; count range 0..DEPTH.
REQ-023 Queue entries are never overwritten while valid.

Reset
REQ-024 reset=1 at posedge: pc<=0, count<=0, pointers<=0; inst_valid=0, inst=0, inst_pc=0 the following cycle.
REQ-025 Reset dominates br_taken and push/pop in the same cycle.
REQ-026 Reset asserted mid-stream discards all queued instructions; fetch resumes at pc=0.

Structure
REQ-027 Package fetch_pkg holds IMEM_AW=6, INST_W=32, and the queue entry struct (pc, instruction).
REQ-028 One sub-module fetch_fifo (DEPTH entries, push/pop/flush, count) instantiated once; pc logic stays in fetch_ctrl.

Verification
REQ-029 Reset then inst_ready=1 constant -> inst_pc 0,4,8,... on consecutive cycles, inst = imem words 0,1,2.
REQ-030 inst_ready=0 for 5 cycles after reset -> queue fills to 2, inst_pc stays 0, imem_addr holds 2; release -> pcs 0,4,8 without gaps or duplicates.
REQ-031 br_taken=1, br_target=0x40 while queue full -> next cycle inst_valid=0; following cycle inst_pc=0x40, imem_addr was 16.
REQ-032 br_target=0x43 -> treated as 0x40.
REQ-033 Run from pc 0xF8 -> imem_addr 62,63,0,1; inst_pc 0xF8,0xFC,0x100,0x104.
REQ-034 reset asserted with 2 entries queued and br_taken=1 -> next cycle inst_valid=0, pc=0; first post-reset inst_pc=0.
